// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: command opcodes and FSM state encodings shared by timer_ctrl and its bench
package timer_ctrl_pkg;
  typedef enum logic [1:0] {OP_START = 2'b00, OP_STOP = 2'b01, OP_PAUSE = 2'b10, OP_RESUME = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11} state_e;
endpackage

// File: rtl/ctrl_bin_counter.sv
// ctrl_bin_counter: N-bit up-counter; clk, clr (sync to 0, wins), en (increment), q (count)
module ctrl_bin_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) q <= clr ? '0 : en ? q + N'(1) : q;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: command-driven timer FSM; clk, reset (sync active-low), cmd_valid/ready/op/period/oneshot in, q/busy/done/expire_tick/cmd_err out
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_period,
  input  logic         cmd_oneshot,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         expire_tick,
  output logic         cmd_err
);
  state_e         state_q;
  logic [N-1:0]   p_q;
  logic           oneshot_q;
  logic           cmd_err_q;
  logic           acc;
  logic           clr;
  logic           en;
  op_e            op;
  assign op          = op_e'(cmd_op);
  assign cmd_ready   = reset;
  assign acc         = cmd_valid & cmd_ready;
  assign expire_tick = (state_q == S_RUN) && (q == p_q);
  assign busy        = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done        = state_q == S_DONE;
  assign cmd_err     = cmd_err_q;
  assign clr = !reset || (acc && (op == OP_START || op == OP_STOP)) || (!acc && expire_tick && !oneshot_q);
  assign en  = !acc && state_q == S_RUN && !expire_tick;
  ctrl_bin_counter #(.N(N)) u_cnt (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .q   (q)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      oneshot_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= acc && ((op == OP_PAUSE && state_q != S_RUN) || (op == OP_RESUME && state_q != S_PAUSE));
      if (acc && op == OP_START) begin
        p_q       <= cmd_period;
        oneshot_q <= cmd_oneshot;
      end
      state_q <= !acc ? ((expire_tick && oneshot_q) ? S_DONE : state_q)
               : op == OP_START ? S_RUN
               : op == OP_STOP ? S_IDLE
               : (op == OP_PAUSE && state_q == S_RUN) ? S_PAUSE
               : (op == OP_RESUME && state_q == S_PAUSE) ? S_RUN
               : state_q;
    end
  end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;
  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_period;
  logic       cmd_oneshot;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       expire_tick;
  logic       cmd_err;
  int         n_cmp;
  int         n_bad;
  int         ticks;
  timer_ctrl #(.N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_period  (cmd_period),
    .cmd_oneshot (cmd_oneshot),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .expire_tick (expire_tick),
    .cmd_err     (cmd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] per, input logic os);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_period  = per;
    cmd_oneshot = os;
    @(negedge clk);
    cmd_valid   = 1'b0;
  endtask
  initial begin
    clk = 0; reset = 0; cmd_valid = 0; cmd_op = 0; cmd_period = 0; cmd_oneshot = 0;
    n_cmp = 0; n_bad = 0;
    step(); step();
    chk("rst_q", q, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    step();
    chk("rst_ready_after", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_expire", expire_tick, 0);
    // periodic P=4
    send(OP_START, 8'd4, 1'b0);
    for (int i = 0; i < 15; i++) begin
      chk("per_q", q, i % 5);
      chk("per_tick", expire_tick, (i % 5) == 4);
      chk("per_busy", busy, 1);
      step();
    end
    // one-shot P=3
    send(OP_START, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("os_q", q, i);
      chk("os_tick", expire_tick, i == 3);
      chk("os_done", done, 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("os_done_hold", done, 1);
      chk("os_q_hold", q, 3);
      chk("os_tick_off", expire_tick, 0);
      chk("os_busy_off", busy, 0);
      step();
    end
    send(OP_STOP, 8'd0, 1'b0);
    chk("os_stop_q", q, 0);
    chk("os_stop_done", done, 0);
    chk("os_stop_busy", busy, 0);
    // errors
    send(OP_RESUME, 8'd0, 1'b0);
    chk("err_resume_idle", cmd_err, 1);
    chk("err_idle_busy", busy, 0);
    step();
    chk("err_pulse_end", cmd_err, 0);
    send(OP_START, 8'd1, 1'b1);
    step(); step();
    chk("err_pre_done", done, 1);
    send(OP_PAUSE, 8'd0, 1'b0);
    chk("err_pause_done", cmd_err, 1);
    chk("err_still_done", done, 1);
    chk("err_q_held", q, 1);
    step();
    chk("err_pulse_end2", cmd_err, 0);
    cmd_valid = 1; cmd_op = OP_RESUME;
    step();
    chk("err_b2b_1", cmd_err, 1);
    cmd_op = OP_PAUSE;
    step();
    chk("err_b2b_2", cmd_err, 1);
    cmd_valid = 0;
    step();
    chk("err_b2b_end", cmd_err, 0);
    chk("err_b2b_done", done, 1);
    // pause / resume
    send(OP_START, 8'd4, 1'b0);
    step(); step();
    chk("pz_pre_q", q, 2);
    send(OP_PAUSE, 8'd0, 1'b0);
    chk("pz_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      chk("pz_q_hold", q, 2);
      chk("pz_tick", expire_tick, 0);
      chk("pz_err", cmd_err, 0);
      step();
    end
    send(OP_RESUME, 8'd0, 1'b0);
    chk("rs_q", q, 2);
    chk("rs_err", cmd_err, 0);
    chk("rs_tick0", expire_tick, 0);
    step();
    chk("rs_q3", q, 3);
    chk("rs_tick1", expire_tick, 0);
    step();
    chk("rs_q4", q, 4);
    chk("rs_tick2", expire_tick, 1);
    // P=0 periodic, STOP on expiry cycle
    send(OP_START, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("p0_q", q, 0);
      chk("p0_tick", expire_tick, 1);
      if (i < 3) step();
    end
    send(OP_STOP, 8'd0, 1'b0);
    chk("stop_exp_busy", busy, 0);
    chk("stop_exp_tick", expire_tick, 0);
    chk("stop_exp_q", q, 0);
    // P=255
    send(OP_START, 8'd255, 1'b0);
    for (int r = 0; r < 2; r++) begin
      ticks = 0;
      for (int i = 0; i < 255; i++) begin
        ticks += int'(expire_tick);
        step();
      end
      chk("p255_early_ticks", ticks, 0);
      chk("p255_q_top", q, 255);
      chk("p255_tick", expire_tick, 1);
      step();
      chk("p255_wrap_q", q, 0);
      chk("p255_wrap_tick", expire_tick, 0);
    end
    // reset mid-run at q=37
    send(OP_START, 8'd100, 1'b0);
    for (int i = 0; i < 37; i++) step();
    chk("mr_q37", q, 37);
    reset = 0;
    step();
    chk("mr_ready0", cmd_ready, 0);
    chk("mr_q0", q, 0);
    chk("mr_busy0", busy, 0);
    step();
    chk("mr_ready0b", cmd_ready, 0);
    chk("mr_tick0", expire_tick, 0);
    reset = 1;
    #1;
    chk("mr_ready1", cmd_ready, 1);
    step();
    chk("mr_idle_q", q, 0);
    chk("mr_idle_busy", busy, 0);
    chk("mr_idle_done", done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
